mlp_seq_ctrl: RTL and testbench
===============================

MLP_SEQ_CTRL -- requirements
Module: mlp_seq_ctrl

Interface
REQ-001 clk  input  1  single clock; all state updates on its rising edge.
REQ-002 rst  input  1  asynchronous, active-high reset.
REQ-003 inp  input  44  one sample of 11 unsigned 4-bit features; feature k = inp[4k+3:4k], k=0..10.
REQ-004 in_valid  input  1  sample on inp is valid.
REQ-005 in_ready  output  1  block accepts a sample; high only in IDLE.
REQ-006 out  output  20  regression result, zero-extended 19-bit ReLU value; held stable while out_valid=1.
REQ-007 out_valid  output  1  out is valid.
REQ-008 out_ready  input  1  consumer accepts out.
REQ-009 busy  output  1  high in any state other than IDLE.

Function
REQ-010 Block SHALL compute the fixed 11-2-1 MLP on one shared signed MAC, time-multiplexed, one product per cycle.
- Hidden weights h0: -23,72,16,-8,40,-12,34,18,12,-56,-88; bias 688.
- Hidden weights h1: -4,-4,-4,9,0,-8,-7,-8,-4,-8,-7; bias 108.
- Output weights -6 (h0), -4 (h1); bias 27282.
REQ-011 States SHALL be IDLE, L0N0, L0N1, L1, DONE.
REQ-012 Accept edge E0: in_valid=1 and in_ready=1 in IDLE; capture inp; acc<=688; counter k<=0; go to L0N0.
REQ-013 L0N0, edges E1..E11: acc += feature[k]*w0[k], k increments each edge.
- At E11: h0 <= ReLU(final sum), truncated to bits [11:0]; acc<=108; go to L0N1.
REQ-014 L0N1, edges E12..E22: same schedule with h1 weights.
- At E22: h1 <= ReLU(final sum)[11:0]; acc<=27282; go to L1.
REQ-015 L1, edges E23..E24: E23 adds h0*-6; E24 adds h1*-4.
- At E24: out <= ReLU(final sum)[18:0] zero-extended to 20 bits; out_valid<=1; go to DONE.
- Fixed latency: 24 cycles from the accept edge to out_valid.
REQ-016 Arithmetic widths:
- Hidden accumulator: 13-bit signed; features sign-extended as {1'b0,x}.
- Output accumulator: 20-bit signed; h0/h1 treated as unsigned 12-bit.
- Products are exact; no intermediate saturation.
REQ-017 DONE SHALL hold out and out_valid until out_ready=1; on that edge out_valid<=0 and state goes to IDLE.
- out retains its last value.
- in_ready is not asserted in the same cycle, so no back-to-back accept in the DONE->IDLE cycle.
REQ-018 in_valid while busy SHALL be ignored; inp changes after E0 SHALL NOT affect the result.
REQ-019 in_valid with in_valid=0 in IDLE: no state change.

Reset
REQ-020 While rst=1:
- State = IDLE, k=0, acc=0, h0=h1=0, out=0, out_valid=0, busy=0.
- in_ready=1 after rst deasserts.
REQ-021 rst asserted mid-computation SHALL abort the inference immediately; no out_valid is produced for the aborted sample.

Configuration
REQ-022 With macro MLP_SEQ_CNT_EN defined, an extra output inf_cnt (16 bits) SHALL exist.
- Reset value 0.
- Increments by 1 on each out_valid&out_ready edge; wraps 65535->0.
REQ-023 Without MLP_SEQ_CNT_EN, port inf_cnt and its counter SHALL be absent; all other behaviour identical.

Verification
REQ-024 inp=0, out_ready=1 -> out_valid exactly 24 cycles after accept, out=22722 (h0=688, h1=108).
REQ-025 All features=15 -> h1 clipped to 0, h0=763, out=22704.
REQ-026 Only feature1=15, others 0 -> h0=1768, h1=48, out=16482.
REQ-027 out_ready=0 for 10 cycles after out_valid; toggle inp and in_valid -> out stable, in_ready=0; accept on the next IDLE cycle.
REQ-028 Assert rst at E12 of an inference -> out_valid=0, busy=0, out=0; the next sample with inp=0 yields 22722.
REQ-029 MLP_SEQ_CNT_EN defined, 3 completed inferences -> inf_cnt=3; preload to 65535 plus one more inference -> inf_cnt=0.

Source files
------------

// File: rtl/mlp_seq_ctrl.sv
// mlp_seq_ctrl: sequential 11-2-1 MLP on one shared MAC; optional inf_cnt output under MLP_SEQ_CNT_EN
module mlp_seq_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic [43:0] inp,
   input  logic        in_valid,
   output logic        in_ready,
   output logic [19:0] out,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        busy
`ifdef MLP_SEQ_CNT_EN
   ,
   output logic [15:0] inf_cnt
`endif
);
   typedef enum logic [2:0] {IDLE, L0N0, L0N1, L1, DONE} state_t;
   state_t state, state_n;
   logic [43:0] x;
   logic [3:0] k, feat;
   logic signed [19:0] acc, sum;
   logic signed [12:0] mul_a;
   logic signed [7:0] mul_b;
   logic signed [20:0] prod;
   logic [11:0] h0, h1, hid_relu;
   logic last;
   function automatic logic signed [7:0] w0(input logic [3:0] i);
      case (i)
         4'd0: w0 = -8'sd23;  4'd1: w0 = 8'sd72;   4'd2: w0 = 8'sd16;
         4'd3: w0 = -8'sd8;   4'd4: w0 = 8'sd40;   4'd5: w0 = -8'sd12;
         4'd6: w0 = 8'sd34;   4'd7: w0 = 8'sd18;   4'd8: w0 = 8'sd12;
         4'd9: w0 = -8'sd56;  default: w0 = -8'sd88;
      endcase
   endfunction
   function automatic logic signed [7:0] w1(input logic [3:0] i);
      case (i)
         4'd3: w1 = 8'sd9;    4'd4: w1 = 8'sd0;    4'd5, 4'd7, 4'd9: w1 = -8'sd8;
         4'd6, 4'd10: w1 = -8'sd7;
         default: w1 = -8'sd4;
      endcase
   endfunction
   assign in_ready = (state == IDLE);
   assign busy = (state != IDLE);
   // MAC operand select, hidden ReLU on the 13-bit sum, and next-state
   always_comb begin
      feat = 4'(x >> {k, 2'b00});
      mul_a = (state == L1) ? (k[0] ? {1'b0, h1} : {1'b0, h0}) : {9'd0, feat};
      mul_b = (state == L1) ? (k[0] ? -8'sd4 : -8'sd6) : ((state == L0N1) ? w1(k) : w0(k));
      prod = mul_a * mul_b;
      sum = acc + prod[19:0];
      hid_relu = sum[12] ? 12'd0 : sum[11:0];
      last = (state == L1) ? (k == 4'd1) : (k == 4'd10);
      state_n = state;
      case (state)
         IDLE: state_n = in_valid ? L0N0 : IDLE;
         L0N0: state_n = last ? L0N1 : L0N0;
         L0N1: state_n = last ? L1 : L0N1;
         L1:   state_n = last ? DONE : L1;
         DONE: state_n = out_ready ? IDLE : DONE;
         default: state_n = IDLE;
      endcase
   end
   // state register and datapath: capture, accumulate, layer hand-off, output hold
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         x <= '0;
         k <= '0;
         acc <= '0;
         h0 <= '0;
         h1 <= '0;
         out <= '0;
         out_valid <= 1'b0;
`ifdef MLP_SEQ_CNT_EN
         inf_cnt <= '0;
`endif
      end else begin
         state <= state_n;
         if (state == IDLE && in_valid) begin
            x <= inp;
            acc <= 20'sd688;
            k <= '0;
         end
         if (state == L0N0 || state == L0N1 || state == L1) begin
            acc <= sum;
            k <= last ? 4'd0 : k + 4'd1;
         end
         if (state == L0N0 && last) begin
            h0 <= hid_relu;
            acc <= 20'sd108;
         end
         if (state == L0N1 && last) begin
            h1 <= hid_relu;
            acc <= 20'sd27282;
         end
         if (state == L1 && last) begin
            out <= sum[19] ? 20'd0 : {1'b0, sum[18:0]};
            out_valid <= 1'b1;
         end
         if (state == DONE && out_ready) begin
            out_valid <= 1'b0;
`ifdef MLP_SEQ_CNT_EN
            inf_cnt <= inf_cnt + 16'd1;
`endif
         end
      end
   end
endmodule

// File: tb/tb_mlp_seq_ctrl.sv
// tb_mlp_seq_ctrl: scoreboard bench for mlp_seq_ctrl
module tb_mlp_seq_ctrl;
   logic clk = 0, rst = 1, in_valid = 0, out_ready = 1;
   logic [43:0] inp = '0;
   logic in_ready, out_valid, busy;
   logic [19:0] out;
`ifdef MLP_SEQ_CNT_EN
   logic [15:0] inf_cnt;
`endif
   int checks = 0, errors = 0;
   int q[$];
   mlp_seq_ctrl dut (
      .clk(clk), .rst(rst), .inp(inp), .in_valid(in_valid), .in_ready(in_ready),
      .out(out), .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
`ifdef MLP_SEQ_CNT_EN
      , .inf_cnt(inf_cnt)
`endif
   );
   always #5 clk = ~clk;
   function automatic int model(input logic [43:0] v);
      int wa[11] = '{-23, 72, 16, -8, 40, -12, 34, 18, 12, -56, -88};
      int wb[11] = '{-4, -4, -4, 9, 0, -8, -7, -8, -4, -8, -7};
      int a = 688, b = 108, o;
      for (int i = 0; i < 11; i++) begin
         a += int'(v[4*i +: 4]) * wa[i];
         b += int'(v[4*i +: 4]) * wb[i];
      end
      a = (a < 0) ? 0 : (a & 4095);
      b = (b < 0) ? 0 : (b & 4095);
      o = 27282 - 6 * a - 4 * b;
      return (o < 0) ? 0 : o;
   endfunction
   function automatic logic [43:0] rnd44();
      logic [63:0] r;
      r = {$urandom, $urandom};
      return r[43:0];
   endfunction
   task automatic do_sample(input logic [43:0] v, input int exp, input int hold, input logic keep);
      int cyc, e;
      logic [19:0] held;
      inp = v; in_valid = 1; out_ready = (hold == 0);
      q.push_back(exp);
      @(posedge clk); #1;
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL accept busy=%b exp=1", busy); end
      in_valid = 0; inp = rnd44();
      cyc = 0;
      while (!out_valid && cyc < 40) begin
         @(posedge clk); #1; cyc++;
         in_valid = 1'($urandom); inp = rnd44();
      end
      in_valid = 0;
      checks++; if (cyc != 24) begin errors++; $display("FAIL latency got=%0d exp=24", cyc); end
      e = (q.size() > 0) ? q.pop_front() : -1;
      checks++; if (out !== 20'(e)) begin errors++; $display("FAIL result got=%0d exp=%0d", out, e); end
      held = out;
      repeat (hold) begin
         in_valid = 1'($urandom); inp = rnd44();
         @(posedge clk); #1;
         checks++;
         if (out !== held || out_valid !== 1'b1 || in_ready !== 1'b0) begin
            errors++; $display("FAIL stall out=%0d exp=%0d ov=%b ir=%b", out, held, out_valid, in_ready);
         end
      end
      out_ready = 1; in_valid = keep; inp = '0;
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || out !== held) begin
         errors++; $display("FAIL release ov=%b ir=%b out=%0d exp=%0d", out_valid, in_ready, out, held);
      end
   endtask
   task automatic test_reset();
      rst = 1;
      repeat (2) @(posedge clk); #1;
      checks++;
      if (out !== 20'd0 || out_valid !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("FAIL reset out=%0d ov=%b busy=%b exp=0/0/0", out, out_valid, busy);
      end
      rst = 0; #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", in_ready); end
   endtask
   task automatic test_vectors();
      do_sample(44'd0, 22722, 0, 0);
      do_sample({44{1'b1}}, 22704, 0, 0);
      do_sample(44'h000_0000_00F0, 16482, 0, 0);
      for (int i = 0; i < 4; i++) begin
         logic [43:0] v;
         v = rnd44();
         do_sample(v, model(v), 0, 0);
      end
   endtask
   task automatic test_backpressure();
      do_sample(44'h123_4567_89AB, model(44'h123_4567_89AB), 10, 0);
   endtask
   task automatic test_back_to_back();
      do_sample(44'hFED_CBA9_8765, model(44'hFED_CBA9_8765), 2, 1);
      do_sample(44'h0F0_F0F0_F0F0, model(44'h0F0_F0F0_F0F0), 0, 0);
   endtask
   task automatic test_reset_abort();
      inp = {44{1'b1}}; in_valid = 1;
      @(posedge clk); #1;
      in_valid = 0;
      repeat (11) @(posedge clk);
      #1 rst = 1; #1;
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || out !== 20'd0) begin
         errors++; $display("FAIL abort ov=%b busy=%b out=%0d exp=0/0/0", out_valid, busy, out);
      end
      @(posedge clk); #1 rst = 0;
      repeat (30) begin
         @(posedge clk); #1;
         checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL abort_quiet ov=%b exp=0", out_valid); end
      end
      do_sample(44'd0, 22722, 0, 0);
   endtask
`ifdef MLP_SEQ_CNT_EN
   task automatic test_counter();
      test_reset();
      repeat (3) do_sample(44'd0, 22722, 0, 0);
      checks++; if (inf_cnt !== 16'd3) begin errors++; $display("FAIL cnt got=%0d exp=3", inf_cnt); end
      force dut.inf_cnt = 16'hFFFF;
      #1 release dut.inf_cnt;
      do_sample(44'd0, 22722, 0, 0);
      checks++; if (inf_cnt !== 16'd0) begin errors++; $display("FAIL cnt_wrap got=%0d exp=0", inf_cnt); end
   endtask
`endif
   initial begin
      test_reset();
      test_vectors();
      test_backpressure();
      test_back_to_back();
      test_reset_abort();
`ifdef MLP_SEQ_CNT_EN
      test_counter();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
